// File: rtl/prog_ctr_unit.sv
// ---------------------------------------------------------------------------
// prog_ctr_unit
//
// Fetch-stage program counter.
//
// The program counter drives a registered instruction memory that has a
// one-cycle read latency. fetch_valid is registered in step with that memory,
// so it qualifies the instruction word that the memory presents in the same
// cycle. That word is the one addressed by prog_ctr in the previous cycle.
// Decode uses fetch_valid to discard wrong-path words after a redirect.
//
// Parameters
//   PROG_CTR_WID  program counter width (address space 2^PROG_CTR_WID words)
//   RESET_VEC     prog_ctr value after reset and after a stack underflow
//   STACK_DEPTH   return-address stack entries (power of 2, at least 2)
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   stall         in   hold prog_ctr and re-read the same address
//   branch_taken  in   redirect to branch_addr
//   call          in   redirect to branch_addr and push link_addr
//   ret           in   redirect to the popped return address
//   branch_addr   in   target for branch_taken and call
//   link_addr     in   return address pushed on call
//   halt          in   stop fetching until reset
//   prog_ctr      out  address to instruction memory
//   fetch_valid   out  instruction memory output this cycle is valid
//   halted        out  sticky halt status
//   stack_err     out  sticky stack overflow/underflow flag
//
// Configuration macro
//   CALL_STACK_EN  When defined, the unit contains a circular return-address
//                  stack. When undefined, call acts exactly like
//                  branch_taken, ret is ignored, and stack_err is tied low.
// ---------------------------------------------------------------------------
module prog_ctr_unit #(
  parameter int PROG_CTR_WID = 10,
  parameter int RESET_VEC    = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    branch_taken,
  input  logic                    call,
  input  logic                    ret,
  input  logic [PROG_CTR_WID-1:0] branch_addr,
  input  logic [PROG_CTR_WID-1:0] link_addr,
  input  logic                    halt,
  output logic [PROG_CTR_WID-1:0] prog_ctr,
  output logic                    fetch_valid,
  output logic                    halted,
  output logic                    stack_err
);

  localparam logic [PROG_CTR_WID-1:0] RESET_PC = RESET_VEC[PROG_CTR_WID-1:0];

  // The single action chosen on this edge, after priority resolution.
  typedef enum logic [2:0] {
    ACT_HALT,
    ACT_POP,
    ACT_CALL,
    ACT_BRANCH,
    ACT_STALL,
    ACT_INC
  } action_e;

  action_e                 action;
  logic [PROG_CTR_WID-1:0] pop_addr;
  logic [PROG_CTR_WID-1:0] pc_next;
  logic                    fv_next;

  // Priority resolution. Lower-priority requests in the same cycle are
  // dropped. Redirects outrank stall. Once halted, nothing else is considered.
  always_comb begin
    action = ACT_INC;
    if (halted || halt) begin
      action = ACT_HALT;
    end
`ifdef CALL_STACK_EN
    else if (ret) begin
      action = ACT_POP;
    end
`endif
    else if (call) begin
      action = ACT_CALL;
    end else if (branch_taken) begin
      action = ACT_BRANCH;
    end else if (stall) begin
      action = ACT_STALL;
    end
  end

  // Next address and next fetch_valid.
  //   Halt or redirect: fetch_valid goes low. This squashes the word
  //   currently in flight through the memory, which is on the wrong path.
  //   Stall: fetch_valid keeps its value, because the same word is re-read.
  //   Increment: the word now leaving the memory is on the correct path.
  always_comb begin
    pc_next = prog_ctr;
    fv_next = 1'b0;
    case (action)
      ACT_HALT: begin
        pc_next = prog_ctr;
        fv_next = 1'b0;
      end
      ACT_POP: begin
        pc_next = pop_addr;
        fv_next = 1'b0;
      end
      ACT_CALL, ACT_BRANCH: begin
        pc_next = branch_addr;
        fv_next = 1'b0;
      end
      ACT_STALL: begin
        pc_next = prog_ctr;
        fv_next = fetch_valid;
      end
      ACT_INC: begin
        // Increment wraps modulo 2^PROG_CTR_WID through natural overflow.
        pc_next = prog_ctr + PROG_CTR_WID'(1);
        fv_next = 1'b1;
      end
      default: begin
        pc_next = prog_ctr;
        fv_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ctr    <= RESET_PC;
      fetch_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      prog_ctr    <= pc_next;
      fetch_valid <= fv_next;
      if (action == ACT_HALT) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef CALL_STACK_EN
  localparam int PTR_WID = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [PTR_WID:0]   FULL_CNT = (PTR_WID + 1)'(STACK_DEPTH);
  localparam logic [PTR_WID:0]   CNT_ONE  = (PTR_WID + 1)'(1);
  localparam logic [PTR_WID-1:0] PTR_ONE  = PTR_WID'(1);

  logic [PROG_CTR_WID-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_WID-1:0]      wr_ptr;
  logic [PTR_WID-1:0]      top_ptr;
  logic [PTR_WID:0]        stack_cnt;
  logic                    stack_empty;
  logic                    stack_full;
  logic                    stack_err_q;

  // wr_ptr always points at the next free slot. The top of stack is the slot
  // just below it. The stack is circular, so a push onto a full stack
  // overwrites the oldest entry. The count saturates at the depth, which
  // means that after an overflow only the newest STACK_DEPTH entries can be
  // popped.
  assign top_ptr     = wr_ptr - PTR_ONE;
  assign stack_empty = (stack_cnt == '0);
  assign stack_full  = (stack_cnt == FULL_CNT);
  assign pop_addr    = stack_empty ? RESET_PC : stack_mem[top_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
      wr_ptr      <= '0;
      stack_cnt   <= '0;
      stack_err_q <= 1'b0;
    end else if (action == ACT_CALL) begin
      stack_mem[wr_ptr] <= link_addr;
      wr_ptr            <= wr_ptr + PTR_ONE;
      if (stack_full) begin
        stack_err_q <= 1'b1;
      end else begin
        stack_cnt <= stack_cnt + CNT_ONE;
      end
    end else if (action == ACT_POP) begin
      if (stack_empty) begin
        stack_err_q <= 1'b1;
      end else begin
        wr_ptr    <= top_ptr;
        stack_cnt <= stack_cnt - CNT_ONE;
      end
    end
  end

  assign stack_err = stack_err_q;
`else
  // No stack. ret never produces ACT_POP, so pop_addr is never selected.
  assign pop_addr  = RESET_PC;
  assign stack_err = 1'b0;

  logic unused_stack_inputs;
  assign unused_stack_inputs = ^{ret, link_addr, STACK_DEPTH[0]};
`endif

endmodule

// File: tb/tb_prog_ctr_unit.sv
// ---------------------------------------------------------------------------
// tb_prog_ctr_unit
//
// Testbench for prog_ctr_unit.
//
// It contains a behavioural reference model that keeps the return stack as a
// queue. A compare process runs on every clock edge and every reset edge and
// checks the DUT against that model. Directed steps add literal expectations.
//
// The same bench covers both builds. Build-specific expectations are selected
// with CALL_STACK_EN.
// ---------------------------------------------------------------------------
module tb_prog_ctr_unit;

  localparam int W     = 10;
  localparam int RVEC  = 0;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic         branch_taken = 1'b0;
  logic         call = 1'b0;
  logic         ret = 1'b0;
  logic [W-1:0] branch_addr = '0;
  logic [W-1:0] link_addr = '0;
  logic         halt = 1'b0;
  logic [W-1:0] prog_ctr;
  logic         fetch_valid;
  logic         halted;
  logic         stack_err;

  int check_cnt = 0;
  int error_cnt = 0;

  // Reference model state
  int m_pc = RVEC;
  int m_fv = 0;
  int m_halted = 0;
  int m_err = 0;
  int m_stack[$];

  prog_ctr_unit #(
    .PROG_CTR_WID(W),
    .RESET_VEC(RVEC),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .call(call),
    .ret(ret),
    .branch_addr(branch_addr),
    .link_addr(link_addr),
    .halt(halt),
    .prog_ctr(prog_ctr),
    .fetch_valid(fetch_valid),
    .halted(halted),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual != expected) begin
      error_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_pc = RVEC;
    m_fv = 0;
    m_halted = 0;
    m_err = 0;
    m_stack.delete();
  endtask

  // One clock edge of the reference behaviour, taken directly from the
  // priority list: halt > ret > call > branch > stall > increment.
  task automatic model_step();
    if (m_halted != 0 || halt) begin
      m_halted = 1;
      m_fv = 0;
    end
`ifdef CALL_STACK_EN
    else if (ret) begin
      if (m_stack.size() == 0) begin
        m_pc = RVEC;
        m_err = 1;
      end else begin
        m_pc = m_stack.pop_back();
      end
      m_fv = 0;
    end
`endif
    else if (call) begin
`ifdef CALL_STACK_EN
      if (m_stack.size() == DEPTH) begin
        m_stack.delete(0);
        m_err = 1;
      end
      m_stack.push_back(int'(link_addr));
`endif
      m_pc = int'(branch_addr);
      m_fv = 0;
    end else if (branch_taken) begin
      m_pc = int'(branch_addr);
      m_fv = 0;
    end else if (stall) begin
      // Hold both prog_ctr and fetch_valid.
    end else begin
      m_pc = (m_pc + 1) % (1 << W);
      m_fv = 1;
    end
  endtask

  // Compare process: update the model on each edge, then check the settled
  // DUT outputs 1 ns later.
  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else model_step();
    #1;
    check_output("model prog_ctr", int'(prog_ctr), m_pc);
    check_output("model fetch_valid", int'(fetch_valid), m_fv);
    check_output("model halted", int'(halted), m_halted);
    check_output("model stack_err", int'(stack_err), m_err);
  end

  // Drive one cycle of requests. The caller is at a negedge. The task returns
  // at the next negedge, after the posedge that consumed the requests.
  task automatic apply_stimulus(input logic st, input logic br, input logic cl,
                                input logic rt, input int addr, input int link,
                                input logic hl);
    stall        = st;
    branch_taken = br;
    call         = cl;
    ret          = rt;
    branch_addr  = W'(addr);
    link_addr    = W'(link);
    halt         = hl;
    @(negedge clk);
  endtask

  task automatic idle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    int exp_ret_pc[5];
    int exp_ret_err[5];
    int exp_call_err[5];
    int halt_pc;
    int exp_pc;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check_output("reset prog_ctr", int'(prog_ctr), 0);
    check_output("reset fetch_valid", int'(fetch_valid), 0);
    check_output("reset halted", int'(halted), 0);
    check_output("reset stack_err", int'(stack_err), 0);
    reset = 1'b0;

    // Test 1: free run from reset
    for (int i = 1; i <= 5; i++) begin
      idle();
      check_output("free run prog_ctr", int'(prog_ctr), i);
      check_output("free run fetch_valid", int'(fetch_valid), 1);
    end

    // Test 2: wrap from 1023 to 0
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1022, 0, 1'b0);
    idle();
    check_output("pre-wrap prog_ctr", int'(prog_ctr), 1023);
    idle();
    check_output("wrap prog_ctr", int'(prog_ctr), 0);
    check_output("wrap fetch_valid", int'(fetch_valid), 1);

    // Test 3: branch squashes one word
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4, 0, 1'b0);
    idle();
    check_output("pre-branch prog_ctr", int'(prog_ctr), 5);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 40, 0, 1'b0);
    check_output("branch prog_ctr", int'(prog_ctr), 40);
    check_output("branch squash", int'(fetch_valid), 0);
    idle();
    check_output("post-branch prog_ctr", int'(prog_ctr), 41);
    check_output("post-branch fetch_valid", int'(fetch_valid), 1);

    // Test 4: stall, with a branch that overrides stall in the middle
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 6, 0, 1'b0);
    idle();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check_output("stall hold prog_ctr", int'(prog_ctr), 7);
    check_output("stall hold fetch_valid", int'(fetch_valid), 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 20, 0, 1'b0);
    check_output("stall+branch prog_ctr", int'(prog_ctr), 20);
    check_output("stall+branch fetch_valid", int'(fetch_valid), 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
    check_output("stall after branch prog_ctr", int'(prog_ctr), 20);
    check_output("stall after branch fetch_valid", int'(fetch_valid), 0);
    idle();
    check_output("resume prog_ctr", int'(prog_ctr), 21);

    // Test 5: nested call/return, then ret and call together
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 100, 8, 1'b0);
    check_output("call1 prog_ctr", int'(prog_ctr), 100);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 200, 101, 1'b0);
    check_output("call2 prog_ctr", int'(prog_ctr), 200);
`ifdef CALL_STACK_EN
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check_output("ret1 prog_ctr", int'(prog_ctr), 101);
    check_output("ret1 fetch_valid", int'(fetch_valid), 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check_output("ret2 prog_ctr", int'(prog_ctr), 8);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 300, 9, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 77, 55, 1'b0);
    check_output("ret+call prog_ctr", int'(prog_ctr), 9);
`else
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check_output("ignored ret1 prog_ctr", int'(prog_ctr), 201);
    check_output("ignored ret1 fetch_valid", int'(fetch_valid), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    check_output("ignored ret2 prog_ctr", int'(prog_ctr), 202);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 300, 9, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 77, 55, 1'b0);
    check_output("ret+call prog_ctr", int'(prog_ctr), 77);
`endif
    check_output("call/ret stack_err", int'(stack_err), 0);

    // Asynchronous reset in mid-cycle
    reset = 1'b1;
    #2;
    check_output("async reset prog_ctr", int'(prog_ctr), RVEC);
    check_output("async reset fetch_valid", int'(fetch_valid), 0);
    @(negedge clk);
    reset = 1'b0;

    // Test 6: overflow, underflow, then halt
`ifdef CALL_STACK_EN
    exp_call_err = '{0, 0, 0, 0, 1};
    exp_ret_pc   = '{5, 4, 3, 2, 0};
    exp_ret_err  = '{1, 1, 1, 1, 1};
    halt_pc      = 1;
`else
    exp_call_err = '{0, 0, 0, 0, 0};
    exp_ret_pc   = '{51, 52, 53, 54, 55};
    exp_ret_err  = '{0, 0, 0, 0, 0};
    halt_pc      = 56;
`endif
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 10 * i, i, 1'b0);
      check_output("deep call prog_ctr", int'(prog_ctr), 10 * i);
      check_output("deep call stack_err", int'(stack_err), exp_call_err[i-1]);
    end
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
      check_output("unwind prog_ctr", int'(prog_ctr), exp_ret_pc[i]);
      check_output("unwind stack_err", int'(stack_err), exp_ret_err[i]);
    end
    idle();
    check_output("pre-halt prog_ctr", int'(prog_ctr), halt_pc);
    check_output("pre-halt fetch_valid", int'(fetch_valid), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
    check_output("halt prog_ctr", int'(prog_ctr), halt_pc);
    check_output("halt fetch_valid", int'(fetch_valid), 0);
    check_output("halt halted", int'(halted), 1);
    idle();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 333, 0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 444, 3, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0);
    exp_pc = halt_pc;
    check_output("halted frozen prog_ctr", int'(prog_ctr), exp_pc);
    check_output("halted fetch_valid", int'(fetch_valid), 0);
    check_output("halted sticky", int'(halted), 1);

    reset = 1'b1;
    @(negedge clk);
    check_output("reset clears halted", int'(halted), 0);
    check_output("reset clears stack_err", int'(stack_err), 0);
    reset = 1'b0;
    idle();
    check_output("after halt reset prog_ctr", int'(prog_ctr), 1);
    check_output("after halt reset fetch_valid", int'(fetch_valid), 1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
